// File: rtl/traffic_ctrl_np.sv
// traffic_ctrl_np - multi-phase traffic-light controller.
//
// Serves NPH mutually conflicting phases in round-robin order. Phases with
// no latched demand are skipped, and green is extended indefinitely while no
// other phase is waiting. All state changes happen on timer ticks. The ticks
// come from a programmable prescaler, or occur every cycle when TEST=1.
//
// Ports:
//   CK     in   clock, rising edge
//   CLRN   in   asynchronous active-low reset
//   FM     in   [NPH] per-phase demand sensors (level, synchronous to CK)
//   TEST   in   1 = tick every cycle, prescaler bypassed and held at 0
//   FLASH  in   (FLASH_MODE_EN only) 1 = flashing-yellow mode
//   GRN    out  [NPH] green lamps
//   YLW    out  [NPH] yellow lamps
//   RED    out  [NPH] red lamps
//   PHASE  out  index of the phase owning green/yellow
//   TICK   out  one-cycle timer tick strobe
//
// Optional feature macro: FLASH_MODE_EN adds the FLASH input and FLSH state.
module traffic_ctrl_np #(
  parameter int NPH      = 2,
  parameter int PRESCALE = 200,
  parameter int TW       = 4,
  parameter int T_GRN    = 12,
  parameter int T_YLW    = 3,
  parameter int T_ALLRED = 1
) (
  input  logic                                  CK,
  input  logic                                  CLRN,
  input  logic [NPH-1:0]                        FM,
  input  logic                                  TEST,
`ifdef FLASH_MODE_EN
  input  logic                                  FLASH,
`endif
  output logic [NPH-1:0]                        GRN,
  output logic [NPH-1:0]                        YLW,
  output logic [NPH-1:0]                        RED,
  output logic [((NPH > 1) ? $clog2(NPH) : 1)-1:0] PHASE,
  output logic                                  TICK
);

  localparam int PW  = (NPH > 1) ? $clog2(NPH) : 1;
  localparam int PSW = $clog2(PRESCALE);
  localparam logic [PSW-1:0] PRESC_MAX = PSW'(PRESCALE - 1);
  localparam logic [NPH-1:0] ONE_HOT0  = {{(NPH-1){1'b0}}, 1'b1};

`ifdef FLASH_MODE_EN
  typedef enum logic [1:0] {S_ALLRED = 2'd0, S_GREEN = 2'd1, S_YELLOW = 2'd2, S_FLSH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_ALLRED = 2'd0, S_GREEN = 2'd1, S_YELLOW = 2'd2} state_t;
`endif

  state_t          state, state_nxt;
  logic [PW-1:0]   phase, phase_nxt, rr_phase, cand;
  logic [TW-1:0]   timer, timer_nxt;
  logic            first, first_nxt;
  logic [NPH-1:0]  demand, demand_nxt, ph_mask, clr_mask;
  logic [PSW-1:0]  presc;
  logic            tick, foreign, enter_green;
  int              sum;
`ifdef FLASH_MODE_EN
  logic            flash_on, flash_on_nxt;
`endif

  assign tick    = TEST | (presc == PRESC_MAX);
  assign TICK    = tick;
  assign PHASE   = phase;
  assign ph_mask = ONE_HOT0 << phase;
  assign foreign = |(demand & ~ph_mask);

  // Prescaler: wraps at PRESCALE-1; parked at 0 while TEST bypasses it.
  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      presc <= '0;
    end else if (TEST || presc == PRESC_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + PSW'(1);
    end
  end

  // Round-robin search starting after the current phase. Iterating from the
  // farthest candidate down lets the nearest demanded phase win.
  always_comb begin
    rr_phase = phase;
    cand     = phase;
    sum      = 0;
    for (int k = NPH - 1; k >= 1; k--) begin
      sum = int'(phase) + k;
      if (sum >= NPH) sum = sum - NPH;
      cand = PW'(sum);
      if (demand[cand]) rr_phase = cand;
    end
  end

  // Next-state logic; only TICK cycles move the FSM.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    timer_nxt   = timer;
    first_nxt   = first;
    enter_green = 1'b0;
`ifdef FLASH_MODE_EN
    flash_on_nxt = flash_on;
`endif
    if (tick) begin
      case (state)
        S_ALLRED: begin
          if (timer != '0) begin
            timer_nxt = timer - TW'(1);
          end else begin
            enter_green = 1'b1;
            state_nxt   = S_GREEN;
            timer_nxt   = TW'(T_GRN - 1);
            first_nxt   = 1'b0;
            phase_nxt   = first ? '0 : rr_phase;
          end
        end
        S_GREEN: begin
          if (timer != '0) begin
            timer_nxt = timer - TW'(1);
          end else if (foreign) begin
            state_nxt = S_YELLOW;
            timer_nxt = TW'(T_YLW - 1);
          end
        end
        S_YELLOW: begin
          if (timer != '0) begin
            timer_nxt = timer - TW'(1);
          end else begin
            state_nxt = S_ALLRED;
            timer_nxt = TW'(T_ALLRED - 1);
          end
        end
`ifdef FLASH_MODE_EN
        S_FLSH: begin
          state_nxt = S_ALLRED;
          timer_nxt = TW'(T_ALLRED - 1);
          first_nxt = 1'b1;
        end
`endif
        default: state_nxt = S_ALLRED;
      endcase
`ifdef FLASH_MODE_EN
      // FLASH overrides whatever the normal sequence decided.
      if (FLASH) begin
        state_nxt    = S_FLSH;
        phase_nxt    = phase;
        timer_nxt    = timer;
        first_nxt    = first;
        enter_green  = 1'b0;
        flash_on_nxt = (state == S_FLSH) ? ~flash_on : 1'b1;
      end
`endif
    end
  end

  // Demand latches: clearing the phase being granted green wins over a
  // simultaneous sensor hit.
  always_comb begin
    clr_mask   = enter_green ? (ONE_HOT0 << phase_nxt) : '0;
    demand_nxt = (demand | FM) & ~clr_mask;
  end

  // State registers.
  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      state  <= S_ALLRED;
      phase  <= '0;
      timer  <= TW'(T_ALLRED - 1);
      first  <= 1'b1;
      demand <= '0;
`ifdef FLASH_MODE_EN
      flash_on <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      timer  <= timer_nxt;
      first  <= first_nxt;
      demand <= demand_nxt;
`ifdef FLASH_MODE_EN
      flash_on <= flash_on_nxt;
`endif
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    GRN = '0;
    YLW = '0;
    RED = '1;
    case (state)
      S_GREEN: begin
        GRN = ph_mask;
        RED = ~ph_mask;
      end
      S_YELLOW: begin
        YLW = ph_mask;
        RED = ~ph_mask;
      end
`ifdef FLASH_MODE_EN
      S_FLSH: begin
        RED = '0;
        YLW = {NPH{flash_on}};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_np.sv
// tb_traffic_ctrl_np - self-checking bench for traffic_ctrl_np.
// One NPH=2 instance covers reset, extension, demand service, the prescaled
// timing and mid-state reset; one NPH=4 instance covers round-robin order.
module tb_traffic_ctrl_np;

  typedef struct {
    logic [3:0] fm;
    int         n;
    logic [3:0] grn;
    logic [3:0] ylw;
    logic [3:0] red;
    logic [1:0] ph;
  } vec_t;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic       clrn, test, tick, ph;
  logic [1:0] fm, grn, ylw, red;
  logic       clrn4, test4, tick4;
  logic [3:0] fm4, grn4, ylw4, red4;
  logic [1:0] ph4;
`ifdef FLASH_MODE_EN
  logic       flash = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  vec_t tab2[12];
  vec_t tab4[13];

  traffic_ctrl_np #(.NPH(2)) dut (
    .CK(ck), .CLRN(clrn), .FM(fm), .TEST(test),
`ifdef FLASH_MODE_EN
    .FLASH(flash),
`endif
    .GRN(grn), .YLW(ylw), .RED(red), .PHASE(ph), .TICK(tick)
  );

  traffic_ctrl_np #(.NPH(4)) dut4 (
    .CK(ck), .CLRN(clrn4), .FM(fm4), .TEST(test4),
`ifdef FLASH_MODE_EN
    .FLASH(flash),
`endif
    .GRN(grn4), .YLW(ylw4), .RED(red4), .PHASE(ph4), .TICK(tick4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Applies one table row for v.n cycles, checking lamps after every edge.
  task automatic applyStimulus(input int sel, input int idx, input vec_t v);
    for (int c = 0; c < v.n; c++) begin
      if (sel == 0) fm = v.fm[1:0];
      else fm4 = v.fm;
      @(negedge ck);
      if (sel == 0)
        checkOutput($sformatf("np2 row%0d cyc%0d", idx, c),
                    32'({2'b00, grn, 2'b00, ylw, 2'b00, red, 1'b0, ph}),
                    32'({v.grn, v.ylw, v.red, v.ph}));
      else
        checkOutput($sformatf("np4 row%0d cyc%0d", idx, c),
                    32'({grn4, ylw4, red4, ph4}),
                    32'({v.grn, v.ylw, v.red, v.ph}));
    end
  endtask

  initial begin
    int first_tick, last_tick, bad_int, ylw_cnt, first_ylw, first_g0, first_g1;

    //            fm       n   grn      ylw      red      ph
    tab2[0]  = '{4'b0000,  5, 4'b0001, 4'b0000, 4'b0010, 2'd0};
    tab2[1]  = '{4'b0010,  1, 4'b0001, 4'b0000, 4'b0010, 2'd0};
    tab2[2]  = '{4'b0000,  6, 4'b0001, 4'b0000, 4'b0010, 2'd0};
    tab2[3]  = '{4'b0000,  3, 4'b0000, 4'b0001, 4'b0010, 2'd0};
    tab2[4]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0011, 2'd0};
    tab2[5]  = '{4'b0000, 12, 4'b0010, 4'b0000, 4'b0001, 2'd1};
    tab2[6]  = '{4'b0000,  5, 4'b0010, 4'b0000, 4'b0001, 2'd1};
    tab2[7]  = '{4'b0001,  1, 4'b0010, 4'b0000, 4'b0001, 2'd1};
    tab2[8]  = '{4'b0000,  3, 4'b0000, 4'b0010, 4'b0001, 2'd1};
    tab2[9]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0011, 2'd1};
    tab2[10] = '{4'b0000,  1, 4'b0001, 4'b0000, 4'b0010, 2'd0};
    tab2[11] = '{4'b0000, 30, 4'b0001, 4'b0000, 4'b0010, 2'd0};

    tab4[0]  = '{4'b0010,  1, 4'b0001, 4'b0000, 4'b1110, 2'd0};
    tab4[1]  = '{4'b0000, 11, 4'b0001, 4'b0000, 4'b1110, 2'd0};
    tab4[2]  = '{4'b0000,  3, 4'b0000, 4'b0001, 4'b1110, 2'd0};
    tab4[3]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b1111, 2'd0};
    tab4[4]  = '{4'b1001,  1, 4'b0010, 4'b0000, 4'b1101, 2'd1};
    tab4[5]  = '{4'b0000, 11, 4'b0010, 4'b0000, 4'b1101, 2'd1};
    tab4[6]  = '{4'b0000,  3, 4'b0000, 4'b0010, 4'b1101, 2'd1};
    tab4[7]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b1111, 2'd1};
    tab4[8]  = '{4'b0000,  1, 4'b1000, 4'b0000, 4'b0111, 2'd3};
    tab4[9]  = '{4'b0000, 11, 4'b1000, 4'b0000, 4'b0111, 2'd3};
    tab4[10] = '{4'b0000,  3, 4'b0000, 4'b1000, 4'b0111, 2'd3};
    tab4[11] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b1111, 2'd3};
    tab4[12] = '{4'b0000, 20, 4'b0001, 4'b0000, 4'b1110, 2'd0};

    clrn = 1'b0; test = 1'b1; fm = 2'b00;
    clrn4 = 1'b0; test4 = 1'b1; fm4 = 4'b0000;

    // Reset state, then release into green extension with no demand.
    repeat (2) @(negedge ck);
    checkOutput("reset lamps", 32'({grn, ylw, red, ph}), 32'({2'b00, 2'b00, 2'b11, 1'b0}));
    clrn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge ck);
      checkOutput($sformatf("extension cyc%0d", c), 32'({grn, ylw, red}), 32'({2'b01, 2'b00, 2'b10}));
    end
    checkOutput("tick in test", 32'(tick), 32'd1);

    // Demand service sequence from a fresh reset.
    clrn = 1'b0;
    @(negedge ck);
    clrn = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(0, i, tab2[i]);

    // Prescaled timing with FM[1] held high.
    clrn = 1'b0; test = 1'b0; fm = 2'b10;
    @(negedge ck);
    checkOutput("reset tick", 32'(tick), 32'd0);
    clrn = 1'b1;
    first_tick = -1; last_tick = -1; bad_int = 0; ylw_cnt = 0;
    first_ylw = -1; first_g0 = -1; first_g1 = -1;
    for (int k = 0; k < 3500; k++) begin
      if (tick) begin
        if (first_tick < 0) first_tick = k;
        else if (k - last_tick != 200) bad_int++;
        last_tick = k;
      end
      if (ylw[0]) begin
        ylw_cnt++;
        if (first_ylw < 0) first_ylw = k;
      end
      if (grn == 2'b01 && first_g0 < 0) first_g0 = k;
      if (grn == 2'b10 && first_g1 < 0) first_g1 = k;
      @(negedge ck);
    end
    checkOutput("first tick", 32'(first_tick), 32'd199);
    checkOutput("tick interval errors", 32'(bad_int), 32'd0);
    checkOutput("green0 start", 32'(first_g0), 32'd200);
    checkOutput("yellow start", 32'(first_ylw), 32'd2600);
    checkOutput("yellow cycles", 32'(ylw_cnt), 32'd600);
    checkOutput("green1 start", 32'(first_g1), 32'd3400);

    // Asynchronous reset in the middle of yellow.
    clrn = 1'b0;
    @(negedge ck);
    clrn = 1'b1;
    repeat (2850) @(negedge ck);
    checkOutput("pre-reset yellow", 32'({grn, ylw}), 32'({2'b00, 2'b01}));
    #2 clrn = 1'b0;
    #1 checkOutput("async reset lamps", 32'({grn, ylw, red, ph, tick}), 32'({2'b00, 2'b00, 2'b11, 1'b0, 1'b0}));
    @(negedge ck);
    clrn = 1'b1;
    first_tick = -1; first_g0 = -1;
    for (int k = 0; k <= 200; k++) begin
      if (tick && first_tick < 0) first_tick = k;
      if (grn == 2'b01 && first_g0 < 0) first_g0 = k;
      if (k < 200) @(negedge ck);
    end
    checkOutput("post-reset first tick", 32'(first_tick), 32'd199);
    checkOutput("post-reset green0", 32'(first_g0), 32'd200);

    // Round-robin ordering on four phases.
    clrn4 = 1'b1;
    for (int i = 0; i < 13; i++) applyStimulus(1, i, tab4[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
